inst_mem_loadable: RTL and testbench

Parametrised, synchronous-read instruction memory for the single-cycle/multi-cycle CPU, replacing the fixed combinational instruction store. Depth and base address are set by parameters, and fetches return a registered 32-bit word with valid and fault flags. A byte-serial load port lets a host (UART receiver, test bench) write a program into the array at run time, while the block blocks fetches and tells the CPU to stall.

---
 rtl/inst_mem_loadable.sv | 185 ++++++++++++++++++
 tb/tb_inst_mem_loadable.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_mem_loadable.sv
// inst_mem_loadable
// Synchronous-read instruction memory with a byte-serial program load port.
// Fetches return a registered word one cycle after fetch_en, flagged with
// inst_valid/fault. While a program is being loaded, fetches are dropped
// and 'loading' tells the CPU to stall. Array contents survive reset.
module inst_mem_loadable #(
    parameter int unsigned ADDR_W    = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD  = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       address,
    input  logic              fetch_en,
    output logic [31:0]       instruction,
    output logic              inst_valid,
    output logic              fault,
    input  logic              load_start,
    input  logic [ADDR_W:0]   load_len,
    input  logic [7:0]        load_byte,
    input  logic              load_byte_valid,
    output logic              loading,
    output logic              load_done
);

    localparam int unsigned       DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W:0]   DEPTH_LEN = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   LEN_ONE   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   LEN_ZERO  = {(ADDR_W + 1){1'b0}};
    localparam logic [ADDR_W-1:0] WPTR_ONE  = {{(ADDR_W - 1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] WPTR_ZERO = {ADDR_W{1'b0}};

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_r;
    logic [ADDR_W:0]   len_r;
    logic [ADDR_W-1:0] wptr_r;
    logic [1:0]        bcnt_r;
    logic [23:0]       word_r;
    logic [31:0]       mem_r [DEPTH];

    logic [31:0]       instruction_r;
    logic              inst_valid_r;
    logic              fault_r;
    logic              loading_r;
    logic              load_done_r;

    logic [31:0]       offset_s;
    logic              bad_s;
    logic [ADDR_W-1:0] idx_s;
    logic              we_s;
    logic [31:0]       wdata_s;
    logic              last_s;
    logic [ADDR_W:0]   len_clamp_s;

    assign instruction = instruction_r;
    assign inst_valid  = inst_valid_r;
    assign fault       = fault_r;
    assign loading     = loading_r;
    assign load_done   = load_done_r;

    // Unsigned offset from the base; addresses below BASE_ADDR wrap high and fault.
    assign offset_s = address - BASE_ADDR;

    // Decode fetch legality, word write strobe, last-word detect and length clamp.
    always_comb begin
        bad_s       = (offset_s[1:0] != 2'b00) || (|offset_s[31:ADDR_W+2]);
        idx_s       = offset_s[ADDR_W+1:2];
        wdata_s     = {word_r, load_byte};
        last_s      = (({1'b0, wptr_r} + LEN_ONE) == len_r);
        we_s        = 1'b0;
        len_clamp_s = load_len;
        if ((state_r == ST_LOAD) && load_byte_valid && (bcnt_r == 2'd3)) begin
            we_s = 1'b1;
        end else begin
            we_s = 1'b0;
        end
        if (load_len > DEPTH_LEN) begin
            len_clamp_s = DEPTH_LEN;
        end else begin
            len_clamp_s = load_len;
        end
    end

    // Load controller: RUN/LOAD/DONE sequencing, byte assembly and status flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_RUN;
            len_r       <= LEN_ZERO;
            wptr_r      <= WPTR_ZERO;
            bcnt_r      <= 2'd0;
            word_r      <= 24'h00_0000;
            loading_r   <= 1'b0;
            load_done_r <= 1'b0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    load_done_r <= 1'b0;
                    if (load_start && (load_len != LEN_ZERO)) begin
                        state_r   <= ST_LOAD;
                        len_r     <= len_clamp_s;
                        wptr_r    <= WPTR_ZERO;
                        bcnt_r    <= 2'd0;
                        loading_r <= 1'b1;
                    end else begin
                        loading_r <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    load_done_r <= 1'b0;
                    if (load_byte_valid) begin
                        bcnt_r <= bcnt_r + 2'd1;
                        case (bcnt_r)
                            2'd0:    word_r[23:16] <= load_byte;
                            2'd1:    word_r[15:8]  <= load_byte;
                            2'd2:    word_r[7:0]   <= load_byte;
                            default: begin
                                wptr_r <= wptr_r + WPTR_ONE;
                                if (last_s) begin
                                    state_r     <= ST_DONE;
                                    loading_r   <= 1'b0;
                                    load_done_r <= 1'b1;
                                end
                            end
                        endcase
                    end
                end
                ST_DONE: begin
                    state_r     <= ST_RUN;
                    loading_r   <= 1'b0;
                    load_done_r <= 1'b0;
                end
                default: begin
                    state_r     <= ST_RUN;
                    loading_r   <= 1'b0;
                    load_done_r <= 1'b0;
                end
            endcase
        end
    end

    // Program array write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we_s) begin
            mem_r[wptr_r] <= wdata_s;
        end
    end

    // Registered fetch port: one-cycle read, NOP while a load is in progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instruction_r <= NOP_WORD;
            inst_valid_r  <= 1'b0;
            fault_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (fetch_en) begin
                        inst_valid_r <= 1'b1;
                        if (bad_s) begin
                            instruction_r <= NOP_WORD;
                            fault_r       <= 1'b1;
                        end else begin
                            instruction_r <= mem_r[idx_s];
                            fault_r       <= 1'b0;
                        end
                    end else begin
                        inst_valid_r <= 1'b0;
                        fault_r      <= 1'b0;
                    end
                end
                default: begin
                    instruction_r <= NOP_WORD;
                    inst_valid_r  <= 1'b0;
                    fault_r       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_mem_loadable.sv
// Directed self-checking bench for inst_mem_loadable: one instance with the
// default map (base 0, 256 words) and one relocated, smaller instance sharing
// the same stimulus.
module tb_inst_mem_loadable;

    logic        clk;
    logic        reset;
    logic [31:0] address;
    logic        fetch_en;
    logic        load_start;
    logic [8:0]  load_len;
    logic [4:0]  load_len_b;
    logic [7:0]  load_byte;
    logic        load_byte_valid;

    logic [31:0] instruction;
    logic        inst_valid;
    logic        fault;
    logic        loading;
    logic        load_done;

    logic [31:0] instruction_b;
    logic        inst_valid_b;
    logic        fault_b;
    logic        loading_b;
    logic        load_done_b;

    int tests;
    int failed;

    logic [7:0] prog_a [8];
    logic [7:0] prog_c [6];

    assign load_len_b = load_len[4:0];

    inst_mem_loadable #(
        .ADDR_W    (8),
        .BASE_ADDR (32'h0000_0000),
        .NOP_WORD  (32'h0000_0000)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .address         (address),
        .fetch_en        (fetch_en),
        .instruction     (instruction),
        .inst_valid      (inst_valid),
        .fault           (fault),
        .load_start      (load_start),
        .load_len        (load_len),
        .load_byte       (load_byte),
        .load_byte_valid (load_byte_valid),
        .loading         (loading),
        .load_done       (load_done)
    );

    inst_mem_loadable #(
        .ADDR_W    (4),
        .BASE_ADDR (32'h0040_0000),
        .NOP_WORD  (32'h0000_0013)
    ) dut_b (
        .clk             (clk),
        .reset           (reset),
        .address         (address),
        .fetch_en        (fetch_en),
        .instruction     (instruction_b),
        .inst_valid      (inst_valid_b),
        .fault           (fault_b),
        .load_start      (load_start),
        .load_len        (load_len_b),
        .load_byte       (load_byte),
        .load_byte_valid (load_byte_valid),
        .loading         (loading_b),
        .load_done       (load_done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        prog_a = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        prog_c = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};

        reset           = 1'b0;
        address         = 32'h0000_0000;
        fetch_en        = 1'b0;
        load_start      = 1'b0;
        load_len        = 9'd0;
        load_byte       = 8'h00;
        load_byte_valid = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_instr",     instruction, 32'h0000_0000);
        chk("rst_valid",     {31'd0, inst_valid}, 32'd0);
        chk("rst_fault",     {31'd0, fault}, 32'd0);
        chk("rst_loading",   {31'd0, loading}, 32'd0);
        chk("rst_load_done", {31'd0, load_done}, 32'd0);
        chk("rst_instr_b",   instruction_b, 32'h0000_0013);

        // First fetch after reset
        reset    = 1'b1;
        fetch_en = 1'b1;
        address  = 32'h0000_0000;
        #2;
        chk("pre_edge_instr", instruction, 32'h0000_0000);
        chk("pre_edge_valid", {31'd0, inst_valid}, 32'd0);
        tick();
        chk("fetch0_valid", {31'd0, inst_valid}, 32'd1);
        chk("fetch0_fault", {31'd0, fault}, 32'd0);

        // Load two words, with a gap cycle carrying a fetch and a repeated load_start
        fetch_en   = 1'b0;
        load_start = 1'b1;
        load_len   = 9'd2;
        tick();
        load_start = 1'b0;
        chk("load_entered", {31'd0, loading}, 32'd1);
        chk("load_entered_b", {31'd0, loading_b}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                load_byte_valid = 1'b0;
                fetch_en        = 1'b1;
                address         = 32'h0000_0000;
                load_start      = 1'b1;
                load_len        = 9'd1;
                tick();
                chk("midload_valid",   {31'd0, inst_valid}, 32'd0);
                chk("midload_instr",   instruction, 32'h0000_0000);
                chk("midload_fault",   {31'd0, fault}, 32'd0);
                chk("midload_loading", {31'd0, loading}, 32'd1);
                chk("midload_instr_b", instruction_b, 32'h0000_0013);
                fetch_en   = 1'b0;
                load_start = 1'b0;
                load_len   = 9'd0;
            end
            load_byte       = prog_a[i];
            load_byte_valid = 1'b1;
            tick();
            if (i == 6) begin
                chk("byte7_loading", {31'd0, loading}, 32'd1);
                chk("byte7_done",    {31'd0, load_done}, 32'd0);
            end
        end
        load_byte_valid = 1'b0;
        chk("done_pulse",   {31'd0, load_done}, 32'd1);
        chk("done_loading", {31'd0, loading}, 32'd0);
        chk("done_pulse_b", {31'd0, load_done_b}, 32'd1);
        tick();
        chk("done_cleared", {31'd0, load_done}, 32'd0);

        // Back-to-back fetches of the new program
        fetch_en = 1'b1;
        address  = 32'h0000_0000;
        tick();
        chk("word0",       instruction, 32'h1234_5678);
        chk("word0_valid", {31'd0, inst_valid}, 32'd1);
        address = 32'h0000_0004;
        tick();
        chk("word1",       instruction, 32'h9ABC_DEF0);
        chk("word1_fault", {31'd0, fault}, 32'd0);

        // Alignment and range boundaries
        address = 32'h0000_0402;
        tick();
        chk("misalign_fault", {31'd0, fault}, 32'd1);
        chk("misalign_instr", instruction, 32'h0000_0000);
        chk("misalign_valid", {31'd0, inst_valid}, 32'd1);
        address = 32'h0000_0400;
        tick();
        chk("range_fault", {31'd0, fault}, 32'd1);
        address = 32'h0000_03FC;
        tick();
        chk("top_word_fault", {31'd0, fault}, 32'd0);
        chk("top_word_valid", {31'd0, inst_valid}, 32'd1);

        // Relocated instance
        address = 32'h003F_FFFC;
        tick();
        chk("below_base_fault_b", {31'd0, fault_b}, 32'd1);
        chk("below_base_instr_b", instruction_b, 32'h0000_0013);
        address = 32'h0040_0040;
        tick();
        chk("past_end_fault_b", {31'd0, fault_b}, 32'd1);
        address = 32'h0040_0000;
        tick();
        chk("base_word0_b", instruction_b, 32'h1234_5678);
        chk("base_fault_b", {31'd0, fault_b}, 32'd0);
        address = 32'h0040_0004;
        tick();
        chk("base_word1_b", instruction_b, 32'h9ABC_DEF0);

        // No fetch: data holds, flags low
        fetch_en = 1'b0;
        tick();
        chk("idle_hold_b",  instruction_b, 32'h9ABC_DEF0);
        chk("idle_valid_b", {31'd0, inst_valid_b}, 32'd0);
        chk("idle_fault_b", {31'd0, fault_b}, 32'd0);

        // Reset in the middle of a three-word load
        load_start = 1'b1;
        load_len   = 9'd3;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            load_byte       = prog_c[i];
            load_byte_valid = 1'b1;
            tick();
        end
        load_byte_valid = 1'b0;
        chk("pre_reset_loading", {31'd0, loading}, 32'd1);
        reset = 1'b0;
        #1;
        chk("async_loading", {31'd0, loading}, 32'd0);
        reset    = 1'b1;
        fetch_en = 1'b1;
        address  = 32'h0000_0000;
        tick();
        chk("partial_word0", instruction, 32'hAABB_CCDD);
        address = 32'h0000_0004;
        tick();
        chk("partial_word1", instruction, 32'h9ABC_DEF0);

        // Zero-length load request is ignored; concurrent fetch still served
        address    = 32'h0000_0000;
        load_start = 1'b1;
        load_len   = 9'd0;
        tick();
        chk("zero_len_loading", {31'd0, loading}, 32'd0);
        chk("zero_len_fetch",   instruction, 32'hAABB_CCDD);
        chk("zero_len_valid",   {31'd0, inst_valid}, 32'd1);
        load_start = 1'b0;
        fetch_en   = 1'b0;
        tick();
        chk("zero_len_idle",    {31'd0, loading}, 32'd0);
        chk("zero_len_hold",    instruction, 32'hAABB_CCDD);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
